bus_uart: RTL

- Memory-mapped serial port that acts as a responder on the CPU system bus (BUS_A/BUS_D/BUS_R/BUS_W), the far end of the transfers issued by the fetch and memory stages.
- Has four 16-bit registers, a TX FIFO with an 8N1 serializer, an RX deserializer with an RX FIFO, and a level interrupt output that feeds the PIC.
- Sits beside the other devices on the shared bus.

---
 rtl/bus_uart.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_uart.sv
// bus_uart: memory-mapped 8N1 UART responder on the CPU system bus.
// Four 16-bit registers (DATA, STATUS, DIV, CTRL), TX/RX FIFOs and a level IRQ.
module bus_uart #(
    parameter logic [22:0] BASE    = 23'h7FFFF0,
    parameter int unsigned DEPTH   = 4,
    parameter logic [15:0] DIV_RST = 16'd433
) (
    input  logic        _CLK,
    input  logic        _RST,
    input  logic [22:0] BUS_A,
    inout  wire  [15:0] BUS_D,
    input  logic        BUS_R,
    input  logic        BUS_W,
    output logic        TXD,
    input  logic        RXD,
    output logic        DEV_I
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // bus-side registers
    logic          r_rd_d, r_wr_d;
    logic [15:0]   r_div;
    logic [1:0]    r_ctrl;
    logic          r_ovr, r_ferr, r_dev_i;

    // FIFOs
    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [PW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;

    // TX serializer
    tx_state_t     r_tx_state, w_tx_state_nxt;
    logic [15:0]   r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]    r_tx_bit, w_tx_bit_nxt;
    logic [7:0]    r_tx_sh, w_tx_sh_nxt;
    logic          r_txd, w_txd_nxt, w_tx_pop;

    // RX deserializer
    rx_state_t     r_rx_state, w_rx_state_nxt;
    logic [15:0]   r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]    r_rx_bit, w_rx_bit_nxt;
    logic [7:0]    r_rx_sh, w_rx_sh_nxt;
    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic          w_rx_push, w_rx_ferr;

    logic          w_sel, w_wr, w_rd;
    logic [1:0]    w_off;
    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_tx_busy;
    logic          w_tx_push, w_rx_pop, w_rx_accept, w_rx_ovr;
    logic [7:0]    w_tx_head;
    logic [15:0]   w_rdata;

    assign w_sel = (BUS_A[22:2] == BASE[22:2]);
    assign w_off = BUS_A[1:0];
    // Only the first cycle of a strobe acts; a simultaneous write suppresses the read.
    assign w_wr  = w_sel && BUS_W && !r_wr_d;
    assign w_rd  = w_sel && BUS_R && !r_rd_d && !BUS_W;

    assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_tx_busy  = (r_tx_state != TX_IDLE);
    assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];

    assign w_tx_push   = w_wr && (w_off == 2'd0) && !w_tx_full;
    assign w_rx_pop    = w_rd && (w_off == 2'd0) && !w_rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_rx_accept = w_rx_push && (!w_rx_full || w_rx_pop);
    assign w_rx_ovr    = w_rx_push && w_rx_full && !w_rx_pop;

    // Register read mux
    always_comb begin
        w_rdata = 16'h0000;
        case (w_off)
            2'd0: if (!w_rx_empty) w_rdata = {8'h00, r_rx_mem[r_rx_rp[AW-1:0]]};
            2'd1: w_rdata = {10'd0, r_ferr, w_tx_busy, r_ovr, ~w_rx_empty, w_tx_empty, w_tx_full};
            2'd2: w_rdata = r_div;
            2'd3: w_rdata = {14'd0, r_ctrl};
            default: w_rdata = 16'h0000;
        endcase
    end

    // The master owns the bus while writing, so only a pure read drives it.
    assign BUS_D = (w_sel && BUS_R && !BUS_W) ? w_rdata : 16'hzzzz;
    assign TXD   = r_txd;
    assign DEV_I = r_dev_i;

    // Control/status registers, strobe history, FIFO pointers and IRQ
    always_ff @(posedge _CLK) begin
        if (_RST) begin
            r_rd_d  <= 1'b0;
            r_wr_d  <= 1'b0;
            r_div   <= DIV_RST;
            r_ctrl  <= 2'b00;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_dev_i <= 1'b0;
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            r_rd_d <= BUS_R;
            r_wr_d <= BUS_W;
            if (w_wr && (w_off == 2'd2)) r_div  <= BUS_D;
            if (w_wr && (w_off == 2'd3)) r_ctrl <= BUS_D[1:0];
            if (w_wr && (w_off == 2'd1)) begin
                r_ovr  <= 1'b0;
                r_ferr <= 1'b0;
            end
            if (w_rx_ovr)  r_ovr  <= 1'b1;
            if (w_rx_ferr) r_ferr <= 1'b1;
            if (w_tx_push)   r_tx_wp <= r_tx_wp + PW'(1);
            if (w_tx_pop)    r_tx_rp <= r_tx_rp + PW'(1);
            if (w_rx_accept) r_rx_wp <= r_rx_wp + PW'(1);
            if (w_rx_pop)    r_rx_rp <= r_rx_rp + PW'(1);
            r_dev_i <= (r_ctrl[0] && !w_rx_empty) || (r_ctrl[1] && w_tx_empty && !w_tx_busy);
        end
    end

    // FIFO storage
    always_ff @(posedge _CLK) begin
        if (w_tx_push)   r_tx_mem[r_tx_wp[AW-1:0]] <= BUS_D[7:0];
        if (w_rx_accept) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_sh;
    end

    // TX state register
    always_ff @(posedge _CLK) begin
        if (_RST) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_sh    <= 8'd0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // TX next state: each state lasts r_div+1 clocks; pop on entry to START
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_sh_nxt    = r_tx_sh;
        w_txd_nxt      = r_txd;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_txd_nxt = 1'b1;
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_sh_nxt    = w_tx_head;
                    w_tx_cnt_nxt   = r_div;
                    w_txd_nxt      = 1'b0;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == 16'd0) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_cnt_nxt   = r_div;
                    w_tx_bit_nxt   = 3'd0;
                    w_txd_nxt      = r_tx_sh[0];
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == 16'd0) begin
                    w_tx_cnt_nxt = r_div;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = TX_STOP;
                        w_txd_nxt      = 1'b1;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 3'd1;
                        w_tx_sh_nxt  = {1'b0, r_tx_sh[7:1]};
                        w_txd_nxt    = r_tx_sh[1];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == 16'd0) begin
                    if (!w_tx_empty) begin
                        w_tx_pop       = 1'b1;
                        w_tx_sh_nxt    = w_tx_head;
                        w_tx_cnt_nxt   = r_div;
                        w_txd_nxt      = 1'b0;
                        w_tx_state_nxt = TX_START;
                    end else begin
                        w_txd_nxt      = 1'b1;
                        w_tx_state_nxt = TX_IDLE;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // RX synchronizer and state register
    always_ff @(posedge _CLK) begin
        if (_RST) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_sh    <= 8'd0;
        end else begin
            r_rx_s1    <= RXD;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
        end
    end

    // RX next state: mid-bit sampling, stop bit decides store or framing error
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_sh_nxt    = r_rx_sh;
        w_rx_push      = 1'b0;
        w_rx_ferr      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_s3 && !r_rx_s2) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_cnt_nxt   = r_div >> 1;
                end
            end
            RX_START: begin
                if (r_rx_cnt == 16'd0) begin
                    if (r_rx_s2) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt = RX_DATA;
                        w_rx_cnt_nxt   = r_div;
                        w_rx_bit_nxt   = 3'd0;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == 16'd0) begin
                    w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
                    w_rx_cnt_nxt = r_div;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
                    else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - 16'd1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == 16'd0) begin
                    w_rx_push      = r_rx_s2;
                    w_rx_ferr      = !r_rx_s2;
                    w_rx_state_nxt = RX_IDLE;
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - 16'd1;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

endmodule
